// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-ported data memory between the pipeline MEM
// stage (cpu) and a debug/loader port (dbg). Each access is serialized through
// a three-state FSM. cpu has fixed priority. A starvation counter lets dbg in
// after STARVE_LIMIT consecutive cpu grants made while dbg was waiting.
// Optional feature macro: DMEM_ARB_ALIGN_CHECK_EN. When it is defined,
// word-misaligned requests are rejected in IDLE with ack+err in one cycle.
module dmem_arbiter #(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_err,
   output logic              cpu_stall,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_ack,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              dbg_err,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_adr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {IDLE, BUSY_CPU, BUSY_DBG} state_t;

   state_t            state_q, state_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
   logic              cpu_ack_q, cpu_ack_d;
   logic              dbg_ack_q, dbg_ack_d;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
   logic              cpu_err_q, cpu_err_d;
   logic              dbg_err_q, dbg_err_d;
`endif

   logic              grant_cpu;
   logic              grant_dbg;
   logic [ADDR_W-1:0] grant_addr;
   logic              misaligned;

   // Arbitration in IDLE: cpu wins ties unless dbg has waited STARVE_LIMIT grants
   always_comb begin
      grant_cpu = 1'b0;
      grant_dbg = 1'b0;
      if (state_q == IDLE) begin
         if (cpu_req && dbg_req) begin
            if (starve_cnt_q == LIMIT) grant_dbg = 1'b1;
            else                       grant_cpu = 1'b1;
         end else if (cpu_req) begin
            grant_cpu = 1'b1;
         end else if (dbg_req) begin
            grant_dbg = 1'b1;
         end
      end
      grant_addr = grant_cpu ? cpu_addr : dbg_addr;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
      misaligned = (grant_cpu || grant_dbg) && (grant_addr[1:0] != 2'b00);
`else
      misaligned = 1'b0;
`endif
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // FSM next state: a grant enters the owner's BUSY state, BUSY always lasts one cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (grant_cpu && !misaligned)      state_d = BUSY_CPU;
            else if (grant_dbg && !misaligned) state_d = BUSY_DBG;
         end
         BUSY_CPU: state_d = IDLE;
         BUSY_DBG: state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // FSM outputs: memory driven only while BUSY; enables killed by reset so an aborted write never commits
   always_comb begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_adr   = '0;
      mem_wdata = '0;
      busy      = 1'b0;
      if (state_q != IDLE) begin
         busy      = 1'b1;
         mem_adr   = addr_q;
         mem_wdata = wdata_q;
         mem_read  = ~we_q & ~rst;
         mem_write = we_q & ~rst;
      end
   end

   // Request latching, starvation counting and per-port completion results
   always_comb begin
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      starve_cnt_d = starve_cnt_q;
      cpu_ack_d    = 1'b0;
      dbg_ack_d    = 1'b0;
      cpu_rdata_d  = cpu_rdata_q;
      dbg_rdata_d  = dbg_rdata_q;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
      cpu_err_d    = cpu_err_q;
      dbg_err_d    = dbg_err_q;
`endif

      if (grant_cpu || grant_dbg) begin
         we_d    = grant_cpu ? cpu_we : dbg_we;
         addr_d  = grant_addr;
         wdata_d = grant_cpu ? cpu_wdata : dbg_wdata;
      end

      if (grant_cpu && dbg_req && (starve_cnt_q != LIMIT)) starve_cnt_d = starve_cnt_q + 1'b1;
      if (grant_dbg) starve_cnt_d = '0;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
      // Misaligned grant completes immediately without touching memory
      if (misaligned) begin
         if (grant_cpu) begin
            cpu_ack_d   = 1'b1;
            cpu_err_d   = 1'b1;
            cpu_rdata_d = '0;
         end else begin
            dbg_ack_d   = 1'b1;
            dbg_err_d   = 1'b1;
            dbg_rdata_d = '0;
         end
      end
`endif

      if (state_q == BUSY_CPU) begin
         cpu_ack_d   = 1'b1;
         cpu_rdata_d = we_q ? '0 : mem_rdata;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
         cpu_err_d   = 1'b0;
`endif
      end
      if (state_q == BUSY_DBG) begin
         dbg_ack_d   = 1'b1;
         dbg_rdata_d = we_q ? '0 : mem_rdata;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
         dbg_err_d   = 1'b0;
`endif
      end
   end

   // Datapath and result registers, all cleared by reset
   always_ff @(posedge clk) begin
      if (rst) begin
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         starve_cnt_q <= '0;
         cpu_ack_q    <= 1'b0;
         dbg_ack_q    <= 1'b0;
         cpu_rdata_q  <= '0;
         dbg_rdata_q  <= '0;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
         cpu_err_q    <= 1'b0;
         dbg_err_q    <= 1'b0;
`endif
      end else begin
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         starve_cnt_q <= starve_cnt_d;
         cpu_ack_q    <= cpu_ack_d;
         dbg_ack_q    <= dbg_ack_d;
         cpu_rdata_q  <= cpu_rdata_d;
         dbg_rdata_q  <= dbg_rdata_d;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
         cpu_err_q    <= cpu_err_d;
         dbg_err_q    <= dbg_err_d;
`endif
      end
   end

   assign cpu_ack   = cpu_ack_q;
   assign dbg_ack   = dbg_ack_q;
   assign cpu_rdata = cpu_rdata_q;
   assign dbg_rdata = dbg_rdata_q;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
   assign cpu_err   = cpu_err_q;
   assign dbg_err   = dbg_err_q;
`else
   assign cpu_err   = 1'b0;
   assign dbg_err   = 1'b0;
`endif
   assign cpu_stall = cpu_req & ~cpu_ack_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a small behavioural data memory
// (combinational read, posedge write, word-indexed by byte address [11:2]).
module tb_dmem_arbiter;

   localparam int DW = 32;
   localparam int AW = 32;
   localparam int SL = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          cpu_req, cpu_we, cpu_ack, cpu_err, cpu_stall;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata, cpu_rdata;
   logic          dbg_req, dbg_we, dbg_ack, dbg_err;
   logic [AW-1:0] dbg_addr;
   logic [DW-1:0] dbg_wdata, dbg_rdata;
   logic          mem_read, mem_write, busy;
   logic [AW-1:0] mem_adr;
   logic [DW-1:0] mem_wdata, mem_rdata;

   logic [DW-1:0] mem [0:1023];
   logic          pre_we;
   logic [9:0]    pre_idx;
   logic [DW-1:0] pre_data;

   int nchecks = 0;
   int nerrors = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_LIMIT(SL)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err), .cpu_stall(cpu_stall),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
      .mem_read(mem_read), .mem_write(mem_write), .mem_adr(mem_adr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
   );

   assign mem_rdata = mem[mem_adr[11:2]];

   always @(posedge clk) begin
      if (mem_write)   mem[mem_adr[11:2]] <= mem_wdata;
      else if (pre_we) mem[pre_idx] <= pre_data;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchecks++;
      if (obs !== exp) begin
         nerrors++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [9:0] idx, input logic [DW-1:0] data);
      pre_we   = 1'b1;
      pre_idx  = idx;
      pre_data = data;
      step();
      pre_we   = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
      pre_we = 0; pre_idx = '0; pre_data = '0;
      for (int i = 0; i < 1024; i++) mem[i] = '0;
      step();
      preload(10'd5, 32'hDEADBEEF);
      preload(10'd1, 32'hCAFEF00D);
      preload(10'd2, 32'hAAAA5555);

      // reset state
      check("rst_cpu_ack", cpu_ack, 0);
      check("rst_dbg_ack", dbg_ack, 0);
      check("rst_busy", busy, 0);
      check("rst_cpu_rdata", cpu_rdata, 0);
      check("rst_mem_read", mem_read, 0);
      check("rst_cpu_err", cpu_err, 0);
      rst = 1'b0;
      step();

      // single cpu read of mem[5]
      cpu_req = 1; cpu_we = 0; cpu_addr = 20;
      #1;
      check("rd_c0_stall", cpu_stall, 1);
      check("rd_c0_busy", busy, 0);
      step(); #1;
      check("rd_c1_mem_read", mem_read, 1);
      check("rd_c1_mem_adr", mem_adr, 20);
      check("rd_c1_busy", busy, 1);
      check("rd_c1_stall", cpu_stall, 1);
      check("rd_c1_ack", cpu_ack, 0);
      step(); #1;
      check("rd_c2_ack", cpu_ack, 1);
      check("rd_c2_rdata", cpu_rdata, 32'hDEADBEEF);
      check("rd_c2_stall", cpu_stall, 0);
      check("rd_c2_mem_read", mem_read, 0);
      cpu_req = 0;
      step(); #1;
      check("rd_c3_ack", cpu_ack, 0);
      check("rd_c3_busy", busy, 0);

      // single dbg write of 0x1234 to 2000
      dbg_req = 1; dbg_we = 1; dbg_addr = 2000; dbg_wdata = 32'h1234;
      #1;
      check("wr_c0_mem_write", mem_write, 0);
      step(); #1;
      check("wr_c1_mem_write", mem_write, 1);
      check("wr_c1_mem_adr", mem_adr, 2000);
      check("wr_c1_mem_wdata", mem_wdata, 32'h1234);
      check("wr_c1_mem_read", mem_read, 0);
      step(); #1;
      check("wr_c2_mem_write", mem_write, 0);
      check("wr_c2_dbg_ack", dbg_ack, 1);
      check("wr_c2_dbg_rdata", dbg_rdata, 0);
      check("wr_c2_cpu_ack", cpu_ack, 0);
      dbg_req = 0; dbg_we = 0;
      step();

      // cpu reads the written word back
      cpu_req = 1; cpu_we = 0; cpu_addr = 2000;
      step(); step(); #1;
      check("rb_ack", cpu_ack, 1);
      check("rb_rdata", cpu_rdata, 32'h1234);
      cpu_req = 0;
      step();

      // starvation: both ports request continuously
      cpu_req = 1; cpu_we = 0; cpu_addr = 0;
      dbg_req = 1; dbg_we = 0; dbg_addr = 4;
      for (int c = 0; c <= 12; c++) begin
         #1;
         check($sformatf("st_c%0d_cpu_ack", c), cpu_ack,
               (c == 2 || c == 4 || c == 6 || c == 8 || c == 12) ? 1 : 0);
         check($sformatf("st_c%0d_dbg_ack", c), dbg_ack, (c == 10) ? 1 : 0);
         if (c == 7)  check("st_cnt_full", dut.starve_cnt_q, SL);
         if (c == 9)  check("st_cnt_clear", dut.starve_cnt_q, 0);
         if (c == 10) check("st_dbg_rdata", dbg_rdata, 32'hCAFEF00D);
         if (c == 12) begin
            cpu_req = 0;
            dbg_req = 0;
         end
         step();
      end
      #1;
      check("st_idle", busy, 0);

      // reset during a cpu write to address 8
      cpu_req = 1; cpu_we = 1; cpu_addr = 8; cpu_wdata = 32'h12345678;
      step(); #1;
      check("rm_c1_busy", busy, 1);
      check("rm_c1_mem_write", mem_write, 1);
      rst = 1'b1;
      #1;
      check("rm_c1_write_gated", mem_write, 0);
      step();
      rst = 1'b0; cpu_req = 0; cpu_we = 0;
      #1;
      check("rm_mem2", mem[2], 32'hAAAA5555);
      check("rm_cpu_ack", cpu_ack, 0);
      check("rm_busy", busy, 0);
      check("rm_mem_read", mem_read, 0);
      check("rm_mem_write", mem_write, 0);
      check("rm_mem_adr", mem_adr, 0);
      check("rm_cpu_rdata", cpu_rdata, 0);
      check("rm_dbg_rdata", dbg_rdata, 0);
      check("rm_cnt", dut.starve_cnt_q, 0);
      step(); #1;
      check("rm_next_ack", cpu_ack, 0);

      // misaligned cpu read at address 6
      cpu_req = 1; cpu_we = 0; cpu_addr = 6;
      #1;
      check("al_c0_mem_read", mem_read, 0);
      step(); #1;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
      check("al_c1_ack", cpu_ack, 1);
      check("al_c1_err", cpu_err, 1);
      check("al_c1_rdata", cpu_rdata, 0);
      check("al_c1_mem_read", mem_read, 0);
      check("al_c1_busy", busy, 0);
      cpu_req = 0;
      step(); #1;
      check("al_c2_ack", cpu_ack, 0);
      check("al_c2_mem_read", mem_read, 0);
`else
      check("al_c1_mem_read", mem_read, 1);
      check("al_c1_mem_adr", mem_adr, 6);
      step(); #1;
      check("al_c2_ack", cpu_ack, 1);
      check("al_c2_err", cpu_err, 0);
      check("al_c2_rdata", cpu_rdata, 32'hCAFEF00D);
      cpu_req = 0;
      step();
`endif

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end

endmodule
